// File: rtl/lpc_periph_capture.sv
// LPC I/O and TPM-start peripheral with long-wait SYNC and a capture FIFO.
// Define LPC_CAPTURE_TIMESTAMP_EN to append a 16-bit push timestamp to each record.
module lpc_periph_capture #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [15:0] ADDR_MASK  = 16'hFFF0,
    parameter int          ACCEPT_TPM = 1,
    parameter int          MAX_WAIT   = 8,
    parameter int          DEPTH      = 4,
`ifdef LPC_CAPTURE_TIMESTAMP_EN
    localparam int         REC_W      = 42,
`else
    localparam int         REC_W      = 26,
`endif
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lframe_n_i,
    input  logic [3:0]       lad_i,
    output logic [3:0]       lad_o,
    output logic             lad_oe_o,
    output logic             rd_req_o,
    output logic [15:0]      rd_addr_o,
    input  logic [7:0]       rd_data_i,
    input  logic             rd_ack_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [REC_W-1:0] rec_data_o,
    output logic [AW:0]      rec_level_o,
    output logic [4:0]       state_o
);

    typedef enum logic [4:0] {
        IDLE = 5'd0, CYCTYPE, ADDR0, ADDR1, ADDR2, ADDR3, WDATA0, WDATA1,
        TAR0, TAR1, SYNC, RDATA0, RDATA1, FTAR0, FTAR1, SKIP
    } state_t;

    localparam logic [7:0] MW       = 8'(MAX_WAIT);
    localparam logic [AW:0] FULL_LV = (AW + 1)'(DEPTH);

    state_t           r_state, w_next;
    logic             r_dir, r_tpm, r_ack;
    logic [15:0]      r_addr;
    logic [7:0]       r_data, r_wait;
    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_level;

    logic             w_tpm_start, w_start, w_hit, w_full;
    logic             w_ready, w_timeout, w_push, w_pop, w_take;
    logic [15:0]      w_addr;
    logic [REC_W-1:0] w_rec;

    assign w_tpm_start = (ACCEPT_TPM != 0) && (lad_i == 4'h5);
    assign w_start     = (lad_i == 4'h0) || w_tpm_start;
    assign w_addr      = {r_addr[11:0], lad_i};
    assign w_hit       = ((w_addr ^ BASE_ADDR) & ADDR_MASK) == 16'h0;
    assign w_full      = (r_level == FULL_LV);
    assign w_ready     = (r_dir || r_ack) && !w_full;
    assign w_timeout   = (r_wait == MW);
    assign w_push      = (r_state == SYNC) && lframe_n_i && w_ready;
    assign w_pop       = rec_valid_o && rec_ready_i;
    assign w_take      = rd_ack_i && !r_ack && !r_dir &&
                         (r_state == TAR0 || r_state == TAR1 ||
                          r_state == SYNC);

`ifdef LPC_CAPTURE_TIMESTAMP_EN
    logic [15:0] r_ts;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_ts <= 16'h0;
        else       r_ts <= r_ts + 16'h1;
    end

    assign w_rec = {r_ts, r_dir, r_tpm, r_addr, r_data};
`else
    assign w_rec = {r_dir, r_tpm, r_addr, r_data};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        lad_oe_o = 1'b0;
        lad_o    = 4'hF;
        // LFRAME# low overrides whatever cycle is in flight
        if (!lframe_n_i) begin
            w_next = w_start ? CYCTYPE : IDLE;
        end else begin
            unique case (r_state)
                CYCTYPE: w_next = (lad_i[3:2] != 2'b00) ? SKIP : ADDR0;
                ADDR0:   w_next = ADDR1;
                ADDR1:   w_next = ADDR2;
                ADDR2:   w_next = ADDR3;
                ADDR3:   w_next = !w_hit ? SKIP : (r_dir ? WDATA0 : TAR0);
                WDATA0:  w_next = WDATA1;
                WDATA1:  w_next = TAR0;
                TAR0:    w_next = TAR1;
                TAR1:    w_next = SYNC;
                SYNC:    if (w_ready || w_timeout)
                             w_next = r_dir ? FTAR0 : RDATA0;
                RDATA0:  w_next = RDATA1;
                RDATA1:  w_next = FTAR0;
                FTAR0:   w_next = FTAR1;
                FTAR1:   w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
        unique case (r_state)
            SYNC: begin
                lad_oe_o = 1'b1;
                lad_o    = w_ready ? 4'h0 : (w_timeout ? 4'hA : 4'h6);
            end
            RDATA0: begin
                lad_oe_o = 1'b1;
                lad_o    = r_data[3:0];
            end
            RDATA1: begin
                lad_oe_o = 1'b1;
                lad_o    = r_data[7:4];
            end
            FTAR0:   lad_oe_o = 1'b1;
            default: lad_oe_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dir  <= 1'b0;
            r_tpm  <= 1'b0;
            r_ack  <= 1'b0;
            r_addr <= 16'h0;
            r_data <= 8'h0;
            r_wait <= 8'h0;
        end else if (!lframe_n_i) begin
            r_tpm  <= w_tpm_start;
            r_ack  <= 1'b0;
            r_wait <= 8'h0;
        end else begin
            if (w_take) begin
                r_ack  <= 1'b1;
                r_data <= rd_data_i;
            end
            unique case (r_state)
                CYCTYPE: r_dir <= lad_i[1];
                ADDR0, ADDR1, ADDR2, ADDR3: r_addr <= w_addr;
                WDATA0:  r_data[3:0] <= lad_i;
                WDATA1:  r_data[7:4] <= lad_i;
                SYNC: begin
                    if (!w_ready) begin
                        if (w_timeout) r_data <= 8'hFF;
                        else           r_wait <= r_wait + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= w_rec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_req_o    = (r_state == TAR0) && !r_dir;
    assign rd_addr_o   = r_addr;
    assign rec_valid_o = (r_level != '0);
    assign rec_level_o = r_level;
    assign rec_data_o  = r_mem[r_rptr];
    assign state_o     = r_state;

endmodule
